// File: rtl/zhiwen_resp_emu_if.sv
// Byte-level link between the host-side UART pair and the fingerprint sensor emulator,
// plus the emulated sensor conditions and status strobes.
interface zhiwen_resp_emu_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       finger_on;
    logic       match_ok;
    logic       cmd_seen;
    logic [7:0] last_instr;
    logic       frame_err;

    modport master (
        output rx_data, rx_valid, tx_ready, finger_on, match_ok,
        input  tx_data, tx_valid, cmd_seen, last_instr, frame_err
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready, finger_on, match_ok,
        output tx_data, tx_valid, cmd_seen, last_instr, frame_err
    );
endinterface

// File: rtl/zhiwen_resp_emu.sv
// Fingerprint sensor emulator: parses EF01 command packets from the host UART and
// answers every well-framed packet with a 12-byte acknowledgement carrying a confirm code.
module zhiwen_resp_emu #(
    parameter logic [31:0] ADDR        = 32'hFFFF_FFFF,
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = 50000
) (
    input logic              clk,
    input logic              rst_n,
    zhiwen_resp_emu_if.slave bus
);

    localparam int              TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST_C = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     MAX_LEN_C  = 16'(MAX_LEN);
    localparam logic [3:0]      LAST_IDX_C = 4'd11;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR2, ST_ADDR, ST_PID, ST_LENH,
        ST_LENL, ST_BODY, ST_SUMH, ST_SUML, ST_REPLY
    } state_t;

    function automatic logic [7:0] addr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    addr_byte = ADDR[31:24];
            2'd1:    addr_byte = ADDR[23:16];
            2'd2:    addr_byte = ADDR[15:8];
            2'd3:    addr_byte = ADDR[7:0];
            default: addr_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] confirm_code(input logic sum_ok, input logic [7:0] instr,
                                                input logic finger, input logic match);
        if (!sum_ok) begin
            confirm_code = 8'h01;
        end else begin
            case (instr)
                8'h01:   confirm_code = finger ? 8'h00 : 8'h02;
                8'h04:   confirm_code = match ? 8'h00 : 8'h09;
                default: confirm_code = 8'h00;
            endcase
        end
    endfunction

    // Acknowledge layout: EF 01 ADDR[4] 07 00 03 CC RSUM_H RSUM_L
    function automatic logic [7:0] reply_byte(input logic [3:0] idx, input logic [7:0] cc);
        logic [15:0] rsum;
        rsum = 16'h000A + {8'h00, cc};
        case (idx)
            4'd0:    reply_byte = 8'hEF;
            4'd1:    reply_byte = 8'h01;
            4'd2:    reply_byte = addr_byte(2'd0);
            4'd3:    reply_byte = addr_byte(2'd1);
            4'd4:    reply_byte = addr_byte(2'd2);
            4'd5:    reply_byte = addr_byte(2'd3);
            4'd6:    reply_byte = 8'h07;
            4'd7:    reply_byte = 8'h00;
            4'd8:    reply_byte = 8'h03;
            4'd9:    reply_byte = cc;
            4'd10:   reply_byte = rsum[15:8];
            4'd11:   reply_byte = rsum[7:0];
            default: reply_byte = 8'h00;
        endcase
    endfunction

    state_t        state_r, state_s;
    logic [3:0]    idx_r;
    logic [15:0]   rem_r;
    logic [15:0]   sum_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    lenh_r;
    logic [7:0]    sumh_r;
    logic [7:0]    instr_r;
    logic          first_r;
    logic [7:0]    cc_r;
    logic [7:0]    tx_data_r;
    logic          tx_valid_r;
    logic          cmd_seen_r;
    logic          frame_err_r;
    logic [7:0]    last_instr_r;

    logic          err_s;
    logic          ok_s;
    logic          rx_active_s;
    logic          tmo_hit_s;
    logic          tx_fire_s;
    logic [15:0]   len_s;
    logic          len_bad_s;
    logic          sum_ok_s;

    assign rx_active_s = (state_r != ST_IDLE) && (state_r != ST_REPLY);
    assign tmo_hit_s   = rx_active_s && !bus.rx_valid && (tmo_r == TMO_LAST_C);
    assign tx_fire_s   = tx_valid_r && bus.tx_ready;
    assign len_s       = {lenh_r, bus.rx_data};
    assign len_bad_s   = (len_s < 16'd3) || (len_s > MAX_LEN_C);
    assign sum_ok_s    = ({sumh_r, bus.rx_data} == sum_r);

    assign bus.tx_data    = tx_data_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.cmd_seen   = cmd_seen_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.last_instr = last_instr_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and frame-level verdicts
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        ok_s    = 1'b0;
        if (state_r == ST_REPLY) begin
            if (tx_fire_s && (idx_r == LAST_IDX_C)) begin
                state_s = ST_IDLE;
            end else begin
                state_s = ST_REPLY;
            end
        end else if (tmo_hit_s) begin
            state_s = ST_IDLE;
            err_s   = 1'b1;
        end else if (bus.rx_valid) begin
            case (state_r)
                ST_IDLE: state_s = (bus.rx_data == 8'hEF) ? ST_HDR2 : ST_IDLE;
                ST_HDR2: begin
                    if (bus.rx_data == 8'h01) begin
                        state_s = ST_ADDR;
                    end else if (bus.rx_data == 8'hEF) begin
                        state_s = ST_HDR2;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (bus.rx_data != addr_byte(idx_r[1:0])) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else if (idx_r == 4'd3) begin
                        state_s = ST_PID;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_PID: begin
                    if (bus.rx_data == 8'h01) begin
                        state_s = ST_LENH;
                    end else begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end
                end
                ST_LENH: state_s = ST_LENL;
                ST_LENL: begin
                    if (len_bad_s) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_BODY;
                    end
                end
                ST_BODY: state_s = (rem_r == 16'd1) ? ST_SUMH : ST_BODY;
                ST_SUMH: state_s = ST_SUML;
                ST_SUML: begin
                    state_s = ST_REPLY;
                    err_s   = !sum_ok_s;
                    ok_s    = sum_ok_s;
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Datapath: byte capture, checksum, timeout, reply sequencing and status strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r        <= 4'd0;
            rem_r        <= 16'd0;
            sum_r        <= 16'd0;
            tmo_r        <= '0;
            lenh_r       <= 8'h00;
            sumh_r       <= 8'h00;
            instr_r      <= 8'h00;
            first_r      <= 1'b0;
            cc_r         <= 8'h00;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            cmd_seen_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            last_instr_r <= 8'h00;
        end else begin
            frame_err_r <= err_s;
            cmd_seen_r  <= ok_s;

            if (rx_active_s && !bus.rx_valid) begin
                tmo_r <= tmo_r + TW'(1'b1);
            end else begin
                tmo_r <= '0;
            end

            if (state_s != state_r) begin
                idx_r <= 4'd0;
            end else if ((state_r == ST_ADDR) && bus.rx_valid) begin
                idx_r <= idx_r + 4'd1;
            end else if ((state_r == ST_REPLY) && tx_fire_s) begin
                idx_r <= idx_r + 4'd1;
            end else begin
                idx_r <= idx_r;
            end

            if (bus.rx_valid) begin
                case (state_r)
                    ST_PID:  sum_r <= {8'h00, bus.rx_data};
                    ST_LENH: begin
                        lenh_r <= bus.rx_data;
                        sum_r  <= sum_r + {8'h00, bus.rx_data};
                    end
                    ST_LENL: begin
                        rem_r   <= len_s - 16'd2;
                        sum_r   <= sum_r + {8'h00, bus.rx_data};
                        first_r <= 1'b1;
                    end
                    ST_BODY: begin
                        rem_r   <= rem_r - 16'd1;
                        sum_r   <= sum_r + {8'h00, bus.rx_data};
                        first_r <= 1'b0;
                        if (first_r) begin
                            instr_r <= bus.rx_data;
                        end
                    end
                    ST_SUMH: sumh_r <= bus.rx_data;
                    ST_SUML: begin
                        cc_r <= confirm_code(sum_ok_s, instr_r, bus.finger_on, bus.match_ok);
                        if (sum_ok_s) begin
                            last_instr_r <= instr_r;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // tx_valid low while in REPLY only happens on the first cycle after entry
            if (state_r == ST_REPLY) begin
                if (!tx_valid_r) begin
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= reply_byte(4'd0, cc_r);
                end else if (bus.tx_ready) begin
                    if (idx_r == LAST_IDX_C) begin
                        tx_valid_r <= 1'b0;
                        tx_data_r  <= 8'h00;
                    end else begin
                        tx_data_r <= reply_byte(idx_r + 4'd1, cc_r);
                    end
                end
            end else begin
                tx_valid_r <= 1'b0;
                tx_data_r  <= 8'h00;
            end
        end
    end

endmodule
